// File: rtl/mem_access_sequencer.sv
// Memory access sequencer for LD/LDI/ST/STI/TRAP: drives MAR/MDR strobes and the
// memory handshake, reports completion or an error (illegal op / ready timeout).
module mem_access_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Start,
    input  logic [2:0] i_Op,
    input  logic       i_MemReady,
    output logic       o_MarMuxControl,
    output logic       o_GateMarMux,
    output logic       o_GateMdr,
    output logic       o_LdMar,
    output logic       o_LdMdr,
    output logic       o_MioEn,
    output logic       o_RW,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_READ, S_IND, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0] OP_LD   = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ST   = 3'd2;
    localparam logic [2:0] OP_STI  = 3'd3;
    localparam logic [2:0] OP_TRAP = 3'd4;

    localparam bit               TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state, state_next;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             ind_done;
    logic             op_legal;
    logic             in_access;
    logic             timeout;

    assign op_legal  = (i_Op <= OP_TRAP);
    assign in_access = (state == S_READ) || (state == S_WRITE);
    assign timeout   = TO_EN && (cnt == TO_LAST) && !i_MemReady;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= S_IDLE;
            op       <= OP_LD;
            cnt      <= '0;
            ind_done <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && i_Start && op_legal)
                op <= i_Op;
            // Any state change restarts the wait count, so every READ/WRITE entry starts at 0.
            if (state_next != state)
                cnt <= '0;
            else if (in_access && !i_MemReady)
                cnt <= cnt + CNT_W'(1);
            if (state == S_IDLE)
                ind_done <= 1'b0;
            else if (state == S_IND)
                ind_done <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        o_MarMuxControl = 1'b0;
        o_GateMarMux    = 1'b0;
        o_GateMdr       = 1'b0;
        o_LdMar         = 1'b0;
        o_LdMdr         = 1'b0;
        o_MioEn         = 1'b0;
        o_RW            = 1'b0;
        o_Busy          = (state != S_IDLE);
        o_Done          = 1'b0;
        o_Error         = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Start)
                    state_next = op_legal ? S_ADDR : S_ERR;
            end
            S_ADDR: begin
                o_GateMarMux    = 1'b1;
                o_LdMar         = 1'b1;
                o_MarMuxControl = (op != OP_TRAP);
                // STI goes through READ first to fetch its pointer.
                state_next      = (op == OP_ST) ? S_WRITE : S_READ;
            end
            S_READ: begin
                o_MioEn = 1'b1;
                o_LdMdr = 1'b1;
                if (i_MemReady)
                    state_next = ((op == OP_LDI || op == OP_STI) && !ind_done) ? S_IND : S_DONE;
                else if (timeout)
                    state_next = S_ERR;
            end
            S_IND: begin
                o_GateMdr  = 1'b1;
                o_LdMar    = 1'b1;
                state_next = (op == OP_STI) ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                o_MioEn = 1'b1;
                o_RW    = 1'b1;
                if (i_MemReady)
                    state_next = S_DONE;
                else if (timeout)
                    state_next = S_ERR;
            end
            S_DONE: begin
                o_Done     = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                o_Error    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: each issued request expands into its expected per-cycle output
// trace; a monitor pops and compares one entry per cycle, a memory model answers ready.
module tb_mem_access_sequencer;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op_in = 3'd0;
    logic       ready = 1'b0;
    logic       mar_ctl, gate_mar, gate_mdr, ld_mar, ld_mdr, mio_en, rw, busy, done, err;

    int total = 0;
    int bad   = 0;
    bit mon_off = 1'b0;

    logic [9:0] expq[$];
    int         dq[$];

    mem_access_sequencer #(.MEM_TIMEOUT(T), .CNT_W(3)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Op(op_in), .i_MemReady(ready),
        .o_MarMuxControl(mar_ctl), .o_GateMarMux(gate_mar), .o_GateMdr(gate_mdr),
        .o_LdMar(ld_mar), .o_LdMdr(ld_mdr), .o_MioEn(mio_en), .o_RW(rw),
        .o_Busy(busy), .o_Done(done), .o_Error(err)
    );

    always #5 clk = ~clk;

    // Vector order: mux_ctl gate_mar gate_mdr ld_mar ld_mdr mio rw busy done err
    localparam logic [9:0] V_IND  = 10'b0011000100;
    localparam logic [9:0] V_RD   = 10'b0000110100;
    localparam logic [9:0] V_WR   = 10'b0000011100;
    localparam logic [9:0] V_DONE = 10'b0000000110;
    localparam logic [9:0] V_ERR  = 10'b0000000101;

    function automatic logic [9:0] outs();
        return {mar_ctl, gate_mar, gate_mdr, ld_mar, ld_mdr, mio_en, rw, busy, done, err};
    endfunction

    task automatic check(input string nm, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, want);
        end
    endtask

    // Reference: an op is a list of memory accesses separated by an indirection cycle;
    // each access lasts delay+1 cycles unless the delay reaches T, which aborts.
    task automatic model(input logic [2:0] op, input int d0, input int d1);
        int  d[2];
        int  n_acc;
        bit  wr;
        d[0] = d0;
        d[1] = d1;
        if (op > 3'd4) begin
            expq.push_back(V_ERR);
            return;
        end
        expq.push_back({(op != 3'd4), 1'b1, 1'b0, 1'b1, 6'b000100});
        n_acc = (op == 3'd1 || op == 3'd3) ? 2 : 1;
        for (int a = 0; a < n_acc; a++) begin
            wr = (op == 3'd2) || (op == 3'd3 && a == 1);
            if (a == 1) expq.push_back(V_IND);
            dq.push_back(d[a]);
            if (d[a] >= T) begin
                repeat (T) expq.push_back(wr ? V_WR : V_RD);
                expq.push_back(V_ERR);
                return;
            end
            repeat (d[a] + 1) expq.push_back(wr ? V_WR : V_RD);
        end
        expq.push_back(V_DONE);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            start = ($urandom % 3 == 0);
            op_in = 3'($urandom);
            @(negedge clk);
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL idle_wait t=%0t busy=%b want=0", $time, busy);
        end
    endtask

    task automatic issue(input logic [2:0] op, input int d0, input int d1);
        wait_idle();
        start = 1'b1;
        op_in = op;
        model(op, d0, d1);
        @(negedge clk);
        start = 1'b0;
        op_in = 3'($urandom);
    endtask

    // Memory: ready after the per-access delay; random noise outside accesses.
    initial begin
        bit in_acc = 1'b0;
        int cnt = 0;
        int dly = 0;
        forever begin
            @(negedge clk);
            if (mio_en) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    cnt = 0;
                    dly = (dq.size() > 0) ? dq.pop_front() : 0;
                end
                ready = (cnt == dly);
                cnt++;
            end else begin
                in_acc = 1'b0;
                ready = 1'($urandom);
            end
        end
    end

    initial begin
        logic [9:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && !mon_off) begin
                if (expq.size() > 0) begin
                    w = expq.pop_front();
                    check("trace", outs(), w);
                end else begin
                    check("idle", outs(), 10'b0);
                end
            end
        end
    end

    initial begin
        int r;
        logic [2:0] op;
        #12;
        check("reset_outs", outs(), 10'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_outs", outs(), 10'b0);

        issue(3'd0, 0, 0);      // LD
        issue(3'd4, 3, 0);      // TRAP, ready delayed
        issue(3'd3, 0, 0);      // STI
        issue(3'd0, 4, 0);      // LD timeout
        issue(3'd0, 3, 0);      // LD ready on last allowed cycle
        issue(3'd5, 0, 0);      // illegal
        issue(3'd1, 2, 1);      // LDI with stray starts while busy
        issue(3'd2, 1, 0);      // ST
        issue(3'd3, 1, 5);      // STI timeout on write

        for (int i = 0; i < 150; i++) begin
            r  = $urandom % 9;
            op = (r < 5) ? 3'(r) : 3'(5 + $urandom % 3);
            issue(op, $urandom % 6, $urandom % 6);
        end

        // Reset in the middle of a write.
        wait_idle();
        mon_off = 1'b1;
        start = 1'b1;
        op_in = 3'd2;
        dq.push_back(99);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_write", outs(), V_WR);
        rst = 1'b1;
        #1;
        check("reset_abort", outs(), 10'b0);
        @(negedge clk);
        @(negedge clk);
        expq.delete();
        dq.delete();
        rst = 1'b0;
        mon_off = 1'b0;
        issue(3'd0, 0, 0);
        issue(3'd1, 0, 0);

        wait_idle();
        repeat (3) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL leftover_trace count=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multi-cycle controller that sequences memory accesses for LD, LDI, ST, STI and TRAP. It drives the MAR mux select and its bus gate, MAR/MDR loads, memory enable and read/write, and waits on the memory ready handshake. It sits between the control store, which issues a start with an opcode, and the datapath muxes and registers. It signals completion or a timeout error.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in a READ or WRITE state without i_MemReady before aborting; 0 disables timeout
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
i_Clk  input  1  system clock, rising-edge
i_Reset  input  1  asynchronous, active-high reset
i_Start  input  1  request pulse from control store; sampled only in IDLE
i_Op  input  3  000 LD, 001 LDI, 010 ST, 011 STI, 100 TRAP; others illegal
i_MemReady  input  1  memory ready (R); sampled only in READ/WRITE
o_MarMuxControl  output  1  1 selects PC/base-derived address, 0 selects zero-extended trap vector
o_GateMarMux  output  1  drives MAR mux output onto bus
o_GateMdr  output  1  drives MDR onto bus
o_LdMar  output  1  load MAR from bus
o_LdMdr  output  1  load MDR from memory
o_MioEn  output  1  memory enable
o_RW  output  1  1 write, 0 read
o_Busy  output  1  high in every state except IDLE
o_Done  output  1  one-cycle completion pulse
o_Error  output  1  one-cycle pulse on illegal opcode or timeout

Behaviour:
- Reset: asynchronous, state forced to IDLE, op register cleared to 000, counter cleared, and every output driven 0 while i_Reset is high and after release until a start is accepted.
- Moore machine: all outputs decode from the state register and captured op only; no input-to-output combinational path.
- States: IDLE, ADDR, READ, IND, WRITE, DONE, ERR. A flag `ind_done` is set on leaving IND and cleared in IDLE.
- IDLE: all outputs 0.
  - i_Start with a legal op: capture op, go to ADDR.
  - i_Start with an illegal op: go to ERR.
  - No start: stay in IDLE.
- ADDR (1 cycle): o_GateMarMux=1, o_LdMar=1, o_MarMuxControl=1 unless op=TRAP (0). Next state is WRITE for ST, READ for all other ops. STI reads its pointer first.
- READ: o_MioEn=1, o_RW=0, o_LdMdr=1. Hold until i_MemReady=1, then:
  - LDI or STI with ind_done=0: go to IND.
  - Otherwise: go to DONE.
- IND (1 cycle): o_GateMdr=1, o_LdMar=1. Next state is READ for LDI, WRITE for STI.
- WRITE: o_MioEn=1, o_RW=1. Hold until i_MemReady=1, then go to DONE.
- DONE (1 cycle): o_Done=1, then IDLE.
- ERR (1 cycle): o_Error=1, then IDLE.
- o_Busy=1 in every state except IDLE.
- Timeout:
  - Counter clears on every entry to READ or WRITE and increments each cycle in those states while i_MemReady=0.
  - If MEM_TIMEOUT≠0 and counter == MEM_TIMEOUT-1 with i_MemReady=0: go to ERR.
  - i_MemReady=1 in that same cycle takes priority (normal completion).
- Latency (start sampled at edge 0, ready present on first cycle of each access):
  - LD, TRAP: ADDR@1, READ@2, DONE@3.
  - ST: ADDR@1, WRITE@2, DONE@3.
  - LDI, STI: ADDR@1, READ@2, IND@3, READ/WRITE@4, DONE@5.
  - Each wait cycle on ready adds one cycle.
- Boundaries:
  - i_Start while busy is ignored and not queued.
  - i_Op is captured only at acceptance; later changes have no effect.
  - i_MemReady outside READ/WRITE is ignored.
  - Reset mid-access aborts immediately with no o_Done or o_Error pulse.
  - Back-to-back: a start presented in the cycle after DONE is accepted.

Test Plan:
- LD, i_MemReady tied 1: start at cycle 0 → ADDR with o_MarMuxControl=1 and o_LdMar=1 at cycle 1; READ at cycle 2; o_Done=1 at cycle 3; o_Busy high for cycles 1-3.
- TRAP with ready delayed 3 cycles: o_MarMuxControl=0 in ADDR; o_MioEn high for 4 cycles; o_Done at cycle 6; o_RW stays 0 throughout.
- STI, ready always 1: state sequence ADDR→READ→IND→WRITE→DONE; o_GateMdr=1 only in IND; o_RW=1 only at cycle 4; o_Done at cycle 5.
- Timeout with MEM_TIMEOUT=4 on LD, ready held 0: READ lasts 4 cycles, then o_Error=1 for 1 cycle, then IDLE with o_Done never asserted. Repeat with ready=1 on the 4th READ cycle → o_Done, no error.
- Illegal op 101: o_Error pulses the cycle after start, o_Busy=1 for that cycle only; no MAR/MDR/memory strobes. Start during LDI READ is ignored: exactly one o_Done pulse.
- Assert i_Reset during WRITE: all outputs 0 in the same cycle, no o_Done; after release, a new LD completes normally in 3 cycles.
